input_checker: RTL and testbench

- Receive-side counterpart of the LED flash path: captures player button presses and encodes each one-hot press into a 2-bit colour code.
- Checks every code against the stored colour sequence, one entry per press, from index 0 up to the current round length.
- Sits between the raw board buttons and the game FSM. Drives the debounced button level back to the LED display path and reports pass/fail for each round.

---
 rtl/simon_pkg.sv | 42 ++++
 rtl/button_debounce.sv | 45 ++++
 rtl/input_checker.sv | 120 ++++++++++++
 tb/tb_input_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types for the Simon game datapath: colour codes, sequence length
// and the input checker state encoding.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COLOUR_0 = 2'b00;
    localparam colour_t COLOUR_1 = 2'b01;
    localparam colour_t COLOUR_2 = 2'b10;
    localparam colour_t COLOUR_3 = 2'b11;

    localparam int SEQ_LEN_DEFAULT = 33;

    typedef struct packed {
        logic    valid;
        colour_t colour;
    } colour_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

    // Anything other than exactly one pressed button is not a colour.
    function automatic colour_code_t onehot_to_colour(input logic [3:0] v);
        colour_code_t r;
        r.valid  = 1'b1;
        r.colour = COLOUR_0;
        case (v)
            4'b0001: r.colour = COLOUR_0;
            4'b0010: r.colour = COLOUR_1;
            4'b0100: r.colour = COLOUR_2;
            4'b1000: r.colour = COLOUR_3;
            default: r.valid  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Per-bit 2-flop synchroniser followed by a stable-count debouncer; a bit's
// level follows the synchronised input only after DEBOUNCE_CYCLES equal samples.
module button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic          sync_a;
        logic          sync_b;
        logic          lvl;
        logic [CW-1:0] cnt;

        // Counter only runs while the synchronised value disagrees with the level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
                lvl    <= 1'b0;
                cnt    <= '0;
            end else begin
                sync_a <= raw[i];
                sync_b <= sync_a;
                if (sync_b == lvl) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl <= sync_b;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level[i] = lvl;
    end

endmodule

// File: rtl/input_checker.sv
// Conditions the player buttons and checks each press against the colour
// sequence. Optional press timeout is enabled by defining INPUT_TIMEOUT_EN.
module input_checker
    import simon_pkg::*;
#(
    parameter int SEQ_LEN         = SEQ_LEN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
`ifdef INPUT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 50_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              buttons,
    input  logic                    start,
    input  logic [5:0]              round_len,
    input  logic [SEQ_LEN-1:0][1:0] segment,
    output logic [3:0]              player_input,
    output logic                    busy,
    output logic [5:0]              check_idx,
    output logic                    round_pass,
    output logic                    round_fail
);

    logic [3:0]   db;
    logic [3:0]   db_q;
    logic         press_evt;
    colour_code_t code;
    chk_state_t   state, state_nx;
    logic [5:0]   idx;
    logic [5:0]   idx_inc;
    logic [5:0]   eff_len;
    logic [5:0]   len_clip;
    logic         timed_out;

    button_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (buttons),
        .level (db)
    );

    // Press is the debounced vector leaving all-zero; buttons held across
    // start therefore need a full release before they count.
    assign press_evt = (db != 4'b0000) && (db_q == 4'b0000);
    assign code      = onehot_to_colour(db);
    assign idx_inc   = idx + 6'd1;
    assign len_clip  = (round_len > 6'(SEQ_LEN)) ? 6'(SEQ_LEN) : round_len;

`ifdef INPUT_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state != ST_WAIT_PRESS)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign timed_out = (state == ST_WAIT_PRESS) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = (len_clip == 6'd0) ? ST_PASS : ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                // A press in the timeout cycle still gets a normal compare.
                if (press_evt)
                    state_nx = (code.valid && code.colour == segment[idx]) ? ST_WAIT_RELEASE : ST_FAIL;
                else if (timed_out)
                    state_nx = ST_FAIL;
            end
            ST_WAIT_RELEASE: begin
                if (db == 4'b0000)
                    state_nx = (idx_inc == eff_len) ? ST_PASS : ST_WAIT_PRESS;
            end
            ST_PASS: state_nx = ST_IDLE;
            ST_FAIL: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            db_q    <= 4'b0000;
            idx     <= '0;
            eff_len <= '0;
        end else begin
            state <= state_nx;
            db_q  <= db;
            if (state == ST_IDLE && start) begin
                idx     <= '0;
                eff_len <= len_clip;
            end else if (state == ST_WAIT_RELEASE && db == 4'b0000) begin
                idx <= idx_inc;
            end
        end
    end

    assign player_input = db;
    assign busy         = (state != ST_IDLE);
    assign check_idx    = idx;
    assign round_pass   = (state == ST_PASS);
    assign round_fail   = (state == ST_FAIL);

endmodule

// File: tb/tb_input_checker.sv
// Directed bench for input_checker: cycle-level behavioural model compared on
// every negedge, plus literal expectations around each scenario.
module tb_input_checker;

    localparam int D  = 4;
    localparam int SL = 33;
    localparam int T  = 20;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [3:0]         buttons = 4'b0;
    logic               start = 1'b0;
    logic [5:0]         round_len = 6'd0;
    logic [SL-1:0][1:0] segment = '0;
    logic [3:0]         player_input;
    logic               busy;
    logic [5:0]         check_idx;
    logic               round_pass;
    logic               round_fail;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_checker #(
        .SEQ_LEN         (SL),
        .DEBOUNCE_CYCLES (D)
`ifdef INPUT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES  (T)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons      (buttons),
        .start        (start),
        .round_len    (round_len),
        .segment      (segment),
        .player_input (player_input),
        .busy         (busy),
        .check_idx    (check_idx),
        .round_pass   (round_pass),
        .round_fail   (round_fail)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: raw-sample history drives the debounced level (a bit takes a
    // new value once the D samples seen through the synchroniser agree);
    // round progress is tracked as plain counters/flags.
    logic [3:0] hist [0:D+1];
    logic [3:0] m_db, m_dbp, nd;
    bit         m_busy, m_pass, m_fail, m_hold, m_press, same;
    int         m_idx, m_len, m_wait;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= D + 1; i++) hist[i] = 4'b0;
            m_db = 4'b0; m_dbp = 4'b0;
            m_busy = 0; m_pass = 0; m_fail = 0; m_hold = 0;
            m_idx = 0; m_len = 0; m_wait = 0;
        end else begin
            m_press = (m_db != 4'b0) && (m_dbp == 4'b0);
            if (m_pass || m_fail) begin
                m_pass = 0; m_fail = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_len  = (int'(round_len) > SL) ? SL : int'(round_len);
                    m_idx  = 0; m_hold = 0; m_wait = 0; m_busy = 1;
                    if (m_len == 0) m_pass = 1;
                end
            end else if (!m_hold) begin
                if (m_press) begin
                    if ($countones(m_db) == 1 && m_db == (4'b0001 << segment[m_idx])) m_hold = 1;
                    else m_fail = 1;
                end
`ifdef INPUT_TIMEOUT_EN
                else if (m_wait == T - 1) m_fail = 1;
                else m_wait++;
`endif
            end else if (m_db == 4'b0) begin
                m_idx++; m_hold = 0; m_wait = 0;
                if (m_idx == m_len) m_pass = 1;
            end
            for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = buttons;
            nd = m_db;
            for (int b = 0; b < 4; b++) begin
                same = 1;
                for (int k = 3; k <= D + 1; k++) if (hist[k][b] != hist[2][b]) same = 0;
                if (same) nd[b] = hist[2][b];
            end
            m_dbp = m_db;
            m_db  = nd;
        end
    end

    int  n_pass = 0, n_fail = 0, pass_idx = -1, fail_idx = -1;
    bit  pi_seen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("player_input", int'(player_input), int'(m_db));
            chk("busy", int'(busy), int'(m_busy));
            chk("check_idx", int'(check_idx), m_idx);
            chk("round_pass", int'(round_pass), int'(m_pass));
            chk("round_fail", int'(round_fail), int'(m_fail));
            if (round_pass) begin n_pass++; pass_idx = int'(check_idx); end
            if (round_fail) begin n_fail++; fail_idx = int'(check_idx); end
            if (player_input != 4'b0) pi_seen = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        round_len = 6'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        buttons = v;
        cyc(10);
        buttons = 4'b0;
        cyc(10);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, " player_input"}, int'(player_input), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " check_idx"}, int'(check_idx), 0);
        chk({tag, " round_pass"}, int'(round_pass), 0);
        chk({tag, " round_fail"}, int'(round_fail), 0);
    endtask

    task automatic set_abc();
        segment[0] = 2'b01; segment[1] = 2'b11; segment[2] = 2'b00;
    endtask

    int p0, f0;

    initial begin
        #1 reset = 1'b1;
        #10 outputs_zero("reset");
        cyc(2);
        reset = 1'b0;
        set_abc();

        // clean three-press round
        p0 = n_pass;
        do_start(3);
        press(4'b0010); press(4'b1000); press(4'b0001);
        cyc(3);
        chk("t1 pass count", n_pass - p0, 1);
        chk("t1 pass idx", pass_idx, 3);
        chk("t1 busy after", int'(busy), 0);

        // wrong second colour
        f0 = n_fail;
        do_start(3);
        press(4'b0010); press(4'b0100);
        cyc(3);
        chk("t2 fail count", n_fail - f0, 1);
        chk("t2 fail idx", fail_idx, 1);
        chk("t2 busy after", int'(busy), 0);

        // two buttons at once
        f0 = n_fail;
        do_start(3);
        press(4'b0011);
        chk("t3 fail count", n_fail - f0, 1);
        chk("t3 fail idx", fail_idx, 0);

        // short glitches on button 2 never reach the debounced level
        f0 = n_fail; p0 = n_pass;
        do_start(1);
        pi_seen = 0;
        repeat (5) begin
            buttons = 4'b0100; cyc(1);
            buttons = 4'b0000; cyc(3);
        end
        cyc(8);
        chk("glitch pi seen", int'(pi_seen), 0);
        chk("glitch busy", int'(busy), 1);
        chk("glitch no fail", n_fail - f0, 0);
        press(4'b0010);
        chk("glitch then pass", n_pass - p0, 1);

        // zero-length round
        p0 = n_pass;
        do_start(0);
        cyc(1);
        chk("len0 pass", n_pass - p0, 1);
        chk("len0 pass idx", pass_idx, 0);

        // start while busy is ignored
        p0 = n_pass;
        do_start(3);
        press(4'b0010);
        do_start(0);
        cyc(3);
        chk("restart ignored pass", n_pass - p0, 0);
        chk("restart ignored idx", int'(check_idx), 1);
        press(4'b1000); press(4'b0001);
        cyc(3);
        chk("restart round pass", n_pass - p0, 1);

        // round_len beyond sequence length is clipped
        for (int i = 0; i < SL; i++) segment[i] = 2'((i * 3 + 1) % 4);
        p0 = n_pass;
        do_start(40);
        for (int i = 0; i < SL; i++) press(4'b0001 << segment[i]);
        cyc(3);
        chk("len40 pass", n_pass - p0, 1);
        chk("len40 pass idx", pass_idx, 33);

        // asynchronous reset mid-round
        set_abc();
        p0 = n_pass; f0 = n_fail;
        do_start(3);
        press(4'b0010); press(4'b1000);
        chk("pre-reset idx", int'(check_idx), 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 outputs_zero("async reset");
        cyc(2);
        reset = 1'b0;
        chk("reset no pass", n_pass - p0, 0);
        chk("reset no fail", n_fail - f0, 0);
        do_start(3);
        chk("after reset idx", int'(check_idx), 0);
        press(4'b0010); press(4'b1000); press(4'b0001);
        cyc(3);
        chk("after reset pass", n_pass - p0, 1);
        chk("after reset pass idx", pass_idx, 3);

`ifdef INPUT_TIMEOUT_EN
        f0 = n_fail;
        do_start(2);
        cyc(30);
        chk("timeout fail", n_fail - f0, 1);
        chk("timeout fail idx", fail_idx, 0);
        // debounced press lands exactly on the timeout cycle
        f0 = n_fail;
        @(negedge clk);
        round_len = 6'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(13);
        buttons = 4'b0010; cyc(10);
        buttons = 4'b0000; cyc(10);
        chk("timeout tie no fail", n_fail - f0, 0);
        chk("timeout tie idx", int'(check_idx), 1);
        chk("timeout tie busy", int'(busy), 1);
`else
        f0 = n_fail;
        do_start(2);
        cyc(40);
        chk("no timeout busy", int'(busy), 1);
        chk("no timeout fail", n_fail - f0, 0);
`endif

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
